data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back / write-allocate data cache.
// Hits are answered in the same cycle the request is presented; misses walk
// IDLE -> [WRITEBACK ->] ALLOCATE -> WAIT_FILL -> IDLE and the held request
// then hits. Lines are 4 words; the backing memory moves whole lines.
module data_cache #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_BYTES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_input_valid,
  input  logic [31:0]  addr,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  din,
  output logic         is_ready,
  output logic         is_output_valid,
  output logic [31:0]  dout,
  output logic         is_hit,
  output logic         mem_req_valid,
  output logic         mem_req_write,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  input  logic         mem_req_ready,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_data
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, WAIT_FILL} state_t;

  state_t              state_q;
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [127:0]        data_mem [NUM_SETS];

  // Miss context captured in the cycle the miss is detected.
  logic [TAG_W-1:0]    miss_tag_q;
  logic [IDX_W-1:0]    miss_idx_q;

  logic                mem_req_valid_q;
  logic                mem_req_write_q;
  logic [31:0]         mem_req_addr_q;

  // Address decode of the incoming request.
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [1:0]          req_off;
  logic                unused_addr_bits;

  assign req_tag          = addr[31 -: TAG_W];
  assign req_idx          = addr[OFF_W +: IDX_W];
  assign req_off          = addr[3:2];
  assign unused_addr_bits = ^addr[1:0];

  logic        req_active;
  logic        tag_match;
  logic        hit;
  logic        miss;
  logic        write_hit;
  logic        victim_dirty;
  logic [31:0] hit_word;

  // A request is only evaluated in IDLE; a write (including read+write) wins.
  assign req_active   = is_input_valid && (mem_read || mem_write);
  assign tag_match    = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit          = (state_q == IDLE) && req_active && tag_match;
  assign miss         = (state_q == IDLE) && req_active && !tag_match;
  assign write_hit    = hit && mem_write;
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  assign hit_word     = data_mem[req_idx][{req_off, 5'b00000} +: 32];

  assign is_ready        = (state_q == IDLE);
  assign is_hit          = hit;
  assign is_output_valid = hit && !mem_write;
  assign dout            = is_output_valid ? hit_word : 32'h0;

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = mem_req_write_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_data  = data_mem[miss_idx_q];

  // Miss FSM, line valid/dirty bookkeeping and registered memory-request outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      miss_tag_q      <= '0;
      miss_idx_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (write_hit) begin
            dirty_q[req_idx] <= 1'b1;
          end else if (miss) begin
            miss_tag_q      <= req_tag;
            miss_idx_q      <= req_idx;
            mem_req_valid_q <= 1'b1;
            if (victim_dirty) begin
              state_q         <= WRITEBACK;
              mem_req_write_q <= 1'b1;
              mem_req_addr_q  <= {tag_mem[req_idx], req_idx, {OFF_W{1'b0}}};
            end else begin
              state_q         <= ALLOCATE;
              mem_req_write_q <= 1'b0;
              mem_req_addr_q  <= {req_tag, req_idx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_req_ready) begin
            state_q         <= ALLOCATE;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (mem_req_ready) begin
            state_q         <= WAIT_FILL;
            mem_req_valid_q <= 1'b0;
          end
        end
        WAIT_FILL: begin
          if (mem_resp_valid) begin
            state_q             <= IDLE;
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data storage: store-hit word update and whole-line fill.
  // NOTE: the arrays carry no reset; valid_q gates every use of their contents,
  // and a fill can only land in WAIT_FILL, which reset forces the FSM out of.
  always_ff @(posedge clk) begin
    if (write_hit) begin
      data_mem[req_idx][{req_off, 5'b00000} +: 32] <= din;
    end
    if ((state_q == WAIT_FILL) && mem_resp_valid) begin
      data_mem[miss_idx_q] <= mem_resp_data;
      tag_mem[miss_idx_q]  <= miss_tag_q;
    end
  end

endmodule
